mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one backing-memory port between instruction-fetch miss refills and data-memory loads/stores.
// - Sits between the fetch/MEM pipeline stages and the unified memory.
// - Sequences each access through a req/ready handshake and returns the read data.
// - Raises per-side stall signals so the pipeline holds while its access is outstanding.
// PARAMETERS
// - ADDR_W    64  address width, all ports
// - DATA_W    64  data width, all ports
// - MAX_WAIT  4   consecutive data grants allowed while fetch waits (ARB_FAIRNESS_EN only); range 1..15
// PORTS
// - clk        in   1       clock; all state updates on rising edge
// - rst        in   1       synchronous, active-high reset
// - if_req     in   1       fetch refill request; level, held until if_done
// - if_addr    in   ADDR_W  fetch address; stable while if_req high
// - if_rdata   out  DATA_W  fetch read data; valid when if_done high
// - if_done    out  1       one-cycle completion pulse, fetch side
// - dm_req     in   1       data request; level, held until dm_done
// - dm_we      in   1       1 = store, 0 = load; stable while dm_req high
// - dm_addr    in   ADDR_W  data address
// - dm_wdata   in   DATA_W  store data
// - dm_rdata   out  DATA_W  load data; valid when dm_done high
// - dm_done    out  1       one-cycle completion pulse, data side
// - mem_valid  out  1       backing-port request valid, registered
// - mem_we     out  1       backing-port write enable
// - mem_addr   out  ADDR_W  backing-port address
// - mem_wdata  out  DATA_W  backing-port write data
// - mem_ready  in   1       backing-port completion; sampled only while mem_valid is high
// - mem_rdata  in   DATA_W  backing-port read data; valid with mem_ready
// - stall_if   out  1       comb: if_req & ~if_done
// - stall_mem  out  1       comb: dm_req & ~dm_done
// - busy       out  1       state != IDLE
// BEHAVIOUR
// - Reset values: all registered outputs are 0; state = IDLE; fairness counter = 0.
// - FSM states: IDLE, BUSY_D, BUSY_I, RESP.
// - IDLE, no request: stay in IDLE.
// - IDLE, any request sampled at edge N: grant one side.
//   - mem_valid/we/addr/wdata are driven from registers in cycle N+1.
//   - Next state is BUSY_D or BUSY_I.
//   - A fetch grant forces mem_we = 0 and mem_wdata = 0.
// - Grant rule (default): data wins whenever dm_req is high.
// - BUSY_x: hold mem_* stable until mem_ready is sampled high at edge M.
//   - At M: capture mem_rdata into x_rdata (store: x_rdata = 0), drop mem_valid, go to RESP.
//   - x_done is high for exactly cycle M+1; the other done stays low.
// - RESP: requests are not sampled; go to IDLE next edge.
//   - The requester drops req in the RESP cycle. A req still high in IDLE is a new access.
// - Throughput: one access per (memory latency + 2) cycles minimum.
//   - Zero-wait memory (mem_ready high in the first valid cycle) gives done 2 cycles after the req edge.
// - x_rdata holds its value until that side's next completion.
// - Simultaneous if_req & dm_req in IDLE: resolved by the grant rule; the loser stays stalled, with no lost request.
// - Request dropped while BUSY: access completes regardless; the done pulse is still issued.
// - rst mid-operation (any state): next edge goes to IDLE.
//   - mem_valid = 0, no done pulse, rdata = 0, counter = 0.
//   - The backing memory tolerates an abandoned request.
// - No address alignment check, no timeout; an address passes unchanged to mem_addr.
// CONFIGURATION
// - Macro ARB_FAIRNESS_EN defined:
//   - A 4-bit wait counter increments on each data grant made while if_req is high.
//   - When the counter reaches MAX_WAIT, the next IDLE arbitration with if_req high grants fetch even if dm_req is high.
//   - The counter clears on any fetch grant, and when if_req is low at arbitration.
// - Macro undefined: strict data priority; the counter is not instantiated. Fetch may starve; the pipeline guarantees it does not.
// STRUCTURE
// - Shared package arm_pkg holds:
//   - the state enum localparams (IDLE=2'd0, BUSY_D=2'd1, BUSY_I=2'd2, RESP=2'd3)
//   - ADDR_W/DATA_W defaults
//   - the GRANT_I/GRANT_D encodings
// - One sub-module: mem_arb_grant_sel.
//   - Combinational grant decision from if_req, dm_req and counter state.
//   - Under ARB_FAIRNESS_EN, it also contains the wait counter register.
// - Top level holds the FSM, mem_* registers, rdata/done registers and stall logic.
// TESTING
// - Reset: rst=1 for 2 cycles with both reqs high -> all outputs 0, busy=0, no mem_valid.
// - Fetch load, 3-cycle memory: if_req with if_addr=0x40, mem_ready on the 3rd valid cycle with rdata=0xDEAD -> mem_valid for cycles 1-3, if_done in cycle 4, if_rdata=0xDEAD, stall_if high until done.
// - Simultaneous reqs: dm store addr=0x100 data=0x5A plus if_req -> data is served first (mem_we=1); fetch is granted in the IDLE after RESP; stall_if held throughout.
// - Fairness (ARB_FAIRNESS_EN, MAX_WAIT=4): dm_req re-issued continuously with if_req high -> 4 data grants, then a fetch grant. Without the macro: data only.
// - Reset mid-access: rst asserted during BUSY_D before mem_ready -> next cycle mem_valid=0, dm_done never pulses, dm_rdata=0.
// - Zero-wait memory, back-to-back data loads: mem_ready tied high -> dm_done every 3 cycles, and reqs are never sampled in RESP.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the memory port arbiter.
// - arm_state_e : arbiter FSM encoding (IDLE, BUSY_D, BUSY_I, RESP)
// - arm_grant_e : which side owns the backing port for the current access
// - ADDR_W_DEF / DATA_W_DEF / MAX_WAIT_DEF : default widths and fairness limit
// - CNT_W       : width of the fetch wait counter (fairness build only)
package arm_pkg;

    localparam int ADDR_W_DEF   = 64;
    localparam int DATA_W_DEF   = 64;
    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } arm_state_e;

    typedef enum logic {
        GRANT_D = 1'b0,
        GRANT_I = 1'b1
    } arm_grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the backing memory.
// Ports of the bundle:
// - fetch side : if_req, if_addr -> if_rdata, if_done, stall_if
// - data side  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_done, stall_mem
// - memory side: mem_valid, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata
// - status     : busy
// Handshake: x_req is a level held until the one-cycle x_done pulse; the
// requester drops it in the cycle x_done is high. mem_valid is registered and
// mem_we/addr/wdata stay stable until mem_ready is seen high at a rising edge
// while mem_valid is high; that edge completes the memory transfer.
// Modports: slave = arbiter, master = pipeline plus memory (the bench).
interface mem_port_arbiter_if
    import arm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done, mem_valid, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done, mem_valid, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, busy
    );

endinterface

// File: rtl/mem_arb_grant_sel.sv
// Grant decision for the memory port arbiter.
// Build option: ARB_FAIRNESS_EN adds a 4-bit wait counter that forces a fetch
// grant after MAX_WAIT data grants made while fetch was waiting; without it,
// data always wins and no register exists here.
// Ports:
// - clk_i, rst_i    : clock / sync reset (fairness build only)
// - arb_en_i        : arbiter is in IDLE and may grant this cycle
// - if_req_i        : fetch request level
// - dm_req_i        : data request level
// - grant_valid_o   : a grant is made this cycle
// - grant_o         : which side is granted (meaningful with grant_valid_o)
module mem_arb_grant_sel
    import arm_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
`ifdef ARB_FAIRNESS_EN
    input  logic       clk_i,
    input  logic       rst_i,
`endif
    input  logic       arb_en_i,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    output logic       grant_valid_o,
    output arm_grant_e grant_o
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("mem_arb_grant_sel: MAX_WAIT must be in 1..15");
    end

    assign grant_valid_o = arb_en_i && (if_req_i || dm_req_i);

`ifdef ARB_FAIRNESS_EN
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             force_if;

    // Fetch has waited long enough: it overrides a pending data request.
    assign force_if = if_req_i && (wait_cnt_q >= CNT_W'(MAX_WAIT));

    always_comb begin
        grant_o    = (dm_req_i && !force_if) ? GRANT_D : GRANT_I;
        wait_cnt_d = wait_cnt_q;
        if (arb_en_i) begin
            if (!if_req_i || grant_o == GRANT_I) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != '1) begin
                // Here if_req is high and data was granted over it.
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign grant_o = dm_req_i ? GRANT_D : GRANT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between fetch refills and data loads/stores.
// Each access runs IDLE -> BUSY_D/BUSY_I -> RESP -> IDLE; the done pulse is
// issued in the RESP cycle and requests are not sampled there.
// Build option: ARB_FAIRNESS_EN enables fetch anti-starvation in the grant
// selector (see mem_arb_grant_sel).
// Ports:
// - clk     : clock, rising edge
// - rst     : synchronous active-high reset
// - bus     : mem_port_arbiter_if.slave (fetch, data, memory, stall, busy)
// - state_o : current FSM state, for observation
module mem_port_arbiter
    import arm_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output arm_state_e          state_o
);

    arm_state_e        state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;

    logic              grant_valid;
    arm_grant_e        grant;
    logic [DATA_W-1:0] rdata_sel;

    mem_arb_grant_sel #(
        .MAX_WAIT(MAX_WAIT)
    ) u_grant_sel (
`ifdef ARB_FAIRNESS_EN
        .clk_i        (clk),
        .rst_i        (rst),
`endif
        .arb_en_i     (state_q == IDLE),
        .if_req_i     (bus.if_req),
        .dm_req_i     (bus.dm_req),
        .grant_valid_o(grant_valid),
        .grant_o      (grant)
    );

    // A store returns zero rather than whatever the memory drives on rdata.
    assign rdata_sel = mem_we_q ? '0 : bus.mem_rdata;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    mem_valid_d = 1'b1;
                    if (grant == GRANT_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_valid_q && bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = RESP;
                    if (state_q == BUSY_D) begin
                        dm_rdata_d = rdata_sel;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = rdata_sel;
                        if_done_d  = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.dm_req & ~dm_done_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset, a table of single accesses with varying
// memory latency, then hand-written sequences for contention, fairness,
// reset mid-access and zero-wait back-to-back loads.
module tb_mem_port_arbiter;
    import arm_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arm_state_e state_dbg;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model controls
    int            lat_cur   = 1;
    logic [DW-1:0] rdata_cur = '0;
    bit            tie_ready = 1'b0;
    int            valid_cnt = 0;

    // Memory model: raises mem_ready on the lat_cur-th cycle that mem_valid is high.
    always @(negedge clk) begin
        if (rst || !bus.mem_valid) begin
            valid_cnt = 0;
            bus.mem_ready = tie_ready;
        end else begin
            valid_cnt = valid_cnt + 1;
            bus.mem_ready = tie_ready || (valid_cnt >= lat_cur);
        end
        bus.mem_rdata = rdata_cur;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", 64'(ok), 64'd1);
    endtask

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] rdata;
        bit          exp_we;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        int          exp_done;
    } vec_t;

    vec_t          vecs[6];
    logic [63:0]   exp_q[$];
    logic [DW-1:0] last_if_rdata;
    logic [DW-1:0] last_dm_rdata;

    initial begin
        // Watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          done_k;
        bit          stall_bad;
        bit          other_bad;
        bit          prev_valid;
        int          grants;
        int          dm_done_k;
        int          if_done_k;
        int          g1_k;
        int          g2_k;
        logic [63:0] g1_addr, g2_addr;
        logic        g1_we, g2_we;
        logic [63:0] g2_wdata;
        bit          found;
        bit          done_bad;

        // Inputs (reset held with both requests high)
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h40;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 64'h100;
        bus.dm_wdata = 64'h5A;

        vecs[0] = '{1'b1, 1'b1, 64'h40, 64'h77, 3, 64'hDEAD, 1'b0, 64'h0, 64'hDEAD, 4};
        vecs[1] = '{1'b0, 1'b0, 64'h200, 64'h99, 1, 64'h1122334455667788, 1'b0, 64'h99, 64'h1122334455667788, 2};
        vecs[2] = '{1'b0, 1'b1, 64'h100, 64'h5A, 2, 64'hFFFF, 1'b1, 64'h5A, 64'h0, 3};
        vecs[3] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hABCD, 1, 64'hA5A5_A5A5_0000_FFFF, 1'b0, 64'h0, 64'hA5A5_A5A5_0000_FFFF, 2};
        vecs[4] = '{1'b0, 1'b0, 64'h8, 64'h0, 4, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 5};
        vecs[5] = '{1'b1, 1'b0, 64'h1000, 64'h0, 2, 64'h0, 1'b0, 64'h0, 64'h0, 3};

        // ---------------- Reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_mem_we",    64'(bus.mem_we),    64'd0);
        check("rst_mem_addr",  bus.mem_addr,       64'd0);
        check("rst_mem_wdata", bus.mem_wdata,      64'd0);
        check("rst_if_rdata",  bus.if_rdata,       64'd0);
        check("rst_dm_rdata",  bus.dm_rdata,       64'd0);
        check("rst_if_done",   64'(bus.if_done),   64'd0);
        check("rst_dm_done",   64'(bus.dm_done),   64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_state",     64'(state_dbg),     64'(IDLE));
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        rst        = 1'b0;
        last_if_rdata = '0;
        last_dm_rdata = '0;

        // ---------------- Table of single accesses ----------------
        foreach (vecs[i]) begin
            v = vecs[i];
            lat_cur   = v.lat;
            rdata_cur = v.rdata;
            wait_idle();
            bus.dm_we    = v.we;
            bus.dm_wdata = v.wdata;
            if (v.is_fetch) begin
                bus.if_req  = 1'b1;
                bus.if_addr = v.addr;
                bus.dm_addr = 64'hBAD0;
            end else begin
                bus.dm_req  = 1'b1;
                bus.dm_addr = v.addr;
                bus.if_addr = 64'hBAD1;
            end
            done_k    = 0;
            stall_bad = 1'b0;
            other_bad = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) begin
                    check($sformatf("v%0d_mem_valid", i), 64'(bus.mem_valid), 64'd1);
                    check($sformatf("v%0d_mem_we", i),    64'(bus.mem_we),    64'(v.exp_we));
                    check($sformatf("v%0d_mem_addr", i),  bus.mem_addr,       v.addr);
                    check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata,      v.exp_wdata);
                end
                if (v.is_fetch ? bus.dm_done : bus.if_done) other_bad = 1'b1;
                if (v.is_fetch ? bus.if_done : bus.dm_done) begin
                    done_k = k;
                    break;
                end
                if (!(v.is_fetch ? bus.stall_if : bus.stall_mem)) stall_bad = 1'b1;
                if (!bus.mem_valid) stall_bad = 1'b1;
            end
            check($sformatf("v%0d_done_cycle", i), 64'(done_k), 64'(v.exp_done));
            check($sformatf("v%0d_stall_valid_held", i), 64'(stall_bad), 64'd0);
            check($sformatf("v%0d_other_done", i), 64'(other_bad), 64'd0);
            check($sformatf("v%0d_valid_dropped", i), 64'(bus.mem_valid), 64'd0);
            if (v.is_fetch) begin
                check($sformatf("v%0d_if_rdata", i), bus.if_rdata, v.exp_rdata);
                check($sformatf("v%0d_dm_rdata_hold", i), bus.dm_rdata, last_dm_rdata);
                check($sformatf("v%0d_stall_off", i), 64'(bus.stall_if), 64'd0);
                last_if_rdata = v.exp_rdata;
                bus.if_req = 1'b0;
            end else begin
                check($sformatf("v%0d_dm_rdata", i), bus.dm_rdata, v.exp_rdata);
                check($sformatf("v%0d_if_rdata_hold", i), bus.if_rdata, last_if_rdata);
                check($sformatf("v%0d_stall_off", i), 64'(bus.stall_mem), 64'd0);
                last_dm_rdata = v.exp_rdata;
                bus.dm_req = 1'b0;
            end
        end

        // ---------------- Simultaneous requests ----------------
        lat_cur   = 1;
        rdata_cur = 64'h77;
        wait_idle();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 64'h100;
        bus.dm_wdata = 64'h5A;
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h40;
        prev_valid = 1'b0;
        grants = 0; dm_done_k = 0; if_done_k = 0; g1_k = 0; g2_k = 0;
        g1_addr = '0; g2_addr = '0; g1_we = 1'b0; g2_we = 1'b1; g2_wdata = '1;
        stall_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_valid && !prev_valid) begin
                grants++;
                if (grants == 1) begin
                    g1_k = k; g1_addr = bus.mem_addr; g1_we = bus.mem_we;
                end else if (grants == 2) begin
                    g2_k = k; g2_addr = bus.mem_addr; g2_we = bus.mem_we; g2_wdata = bus.mem_wdata;
                end
            end
            prev_valid = bus.mem_valid;
            if (bus.dm_done) begin
                dm_done_k = k;
                bus.dm_req = 1'b0;
            end
            if (bus.if_done) begin
                if_done_k = k;
                break;
            end
            if (!bus.stall_if) stall_bad = 1'b1;
        end
        check("sim_g1_cycle", 64'(g1_k), 64'd1);
        check("sim_g1_addr", g1_addr, 64'h100);
        check("sim_g1_we", 64'(g1_we), 64'd1);
        check("sim_dm_done_cycle", 64'(dm_done_k), 64'd2);
        check("sim_g2_cycle", 64'(g2_k), 64'd4);
        check("sim_g2_addr", g2_addr, 64'h40);
        check("sim_g2_we", 64'(g2_we), 64'd0);
        check("sim_g2_wdata", g2_wdata, 64'd0);
        check("sim_if_done_cycle", 64'(if_done_k), 64'd5);
        check("sim_stall_if_held", 64'(stall_bad), 64'd0);
        check("sim_if_rdata", bus.if_rdata, 64'h77);
        check("sim_dm_rdata", bus.dm_rdata, 64'h0);
        bus.if_req = 1'b0;

        // ---------------- Fairness / strict priority ----------------
        lat_cur   = 1;
        rdata_cur = 64'h3C;
        exp_q.delete();
`ifdef ARB_FAIRNESS_EN
        repeat (4) exp_q.push_back(64'h300);
        exp_q.push_back(64'h40);
`else
        repeat (5) exp_q.push_back(64'h300);
`endif
        wait_idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h40;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 64'h300;
        prev_valid = 1'b0;
        grants = 0;
        stall_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_valid && !prev_valid && exp_q.size() > 0) begin
                grants++;
                check($sformatf("fair_grant%0d_addr", grants), bus.mem_addr, exp_q.pop_front());
            end
            prev_valid = bus.mem_valid;
            if (!bus.stall_if) stall_bad = 1'b1;
            if (grants == 5) break;
        end
        check("fair_grant_count", 64'(grants), 64'd5);
        check("fair_stall_if_held", 64'(stall_bad), 64'd0);
        bus.dm_req = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.if_done) begin
                found = 1'b1;
                break;
            end
        end
        check("fair_if_served", 64'(found), 64'd1);
        check("fair_if_rdata", bus.if_rdata, 64'h3C);
        bus.if_req = 1'b0;

        // ---------------- Reset mid-access ----------------
        lat_cur   = 5;
        rdata_cur = 64'h55;
        wait_idle();
        check("rma_dm_rdata_before", bus.dm_rdata, 64'h3C);
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 64'h500;
        @(posedge clk);
        #1;
        check("rma_granted", 64'(bus.mem_valid), 64'd1);
        check("rma_state_busy_d", 64'(state_dbg), 64'(BUSY_D));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rma_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rma_dm_rdata", bus.dm_rdata, 64'd0);
        check("rma_if_rdata", bus.if_rdata, 64'd0);
        check("rma_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        bus.dm_req = 1'b0;
        done_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.dm_done || bus.mem_valid) done_bad = 1'b1;
        end
        check("rma_no_done", 64'(done_bad), 64'd0);

        // ---------------- Zero-wait back-to-back loads ----------------
        tie_ready = 1'b1;
        rdata_cur = 64'h0F0F;
        exp_q.delete();
        exp_q.push_back(64'd2);
        exp_q.push_back(64'd5);
        exp_q.push_back(64'd8);
        exp_q.push_back(64'd11);
        wait_idle();
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 64'h600;
        grants = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (bus.dm_done) begin
                grants++;
                if (exp_q.size() > 0) begin
                    check($sformatf("zw_done%0d_cycle", grants), 64'(k), exp_q.pop_front());
                end else begin
                    check("zw_extra_done", 64'(k), 64'd0);
                end
                check($sformatf("zw_done%0d_valid_low", grants), 64'(bus.mem_valid), 64'd0);
                check($sformatf("zw_done%0d_rdata", grants), bus.dm_rdata, 64'h0F0F);
                if (k == 11) bus.dm_req = 1'b0;
            end
        end
        check("zw_done_count", 64'(grants), 64'd4);
        tie_ready  = 1'b0;
        bus.dm_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
